// File: rtl/byte_serializer.sv
// byte_serializer: one-lane parallel-to-serial converter.
// It takes one 8-bit symbol every eight bit clocks and shifts it out MSB first.
// After reset it sends a fixed train of IDLE_SYMBOL alignment symbols.
// Once aligned, it sends IDLE_SYMBOL filler whenever the upstream byte is not valid.
module byte_serializer #(
    parameter logic [7:0] IDLE_SYMBOL  = 8'hBC,
    parameter int         INIT_SYMBOLS = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load,
    output logic       data_out,
    output logic       symbol_valid,
    output logic       underrun
);

    typedef enum logic {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Symbol index of the final alignment symbol; its boundary is the first one that samples upstream.
    localparam logic [3:0] LAST_INIT = 4'(INIT_SYMBOLS - 1);

    state_t     state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] scnt_q, scnt_d;
    logic       last_data_q, last_data_d;
    logic       sym_valid_q, sym_valid_d;
    logic       underrun_q, underrun_d;

    logic       boundary;
    logic       init_last;
    logic       take_input;
    logic       sel_valid;

    // The last bit of the current symbol is on the line; the next edge loads a new symbol.
    assign boundary  = (cnt_q == 3'd7);
    assign init_last = (scnt_q == LAST_INIT);

    // FSM state register: the alignment train always restarts from INIT on reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave INIT at the boundary that ends the last alignment symbol; ACTIVE is terminal.
    always_comb begin
        state_d = state_q;
        if (boundary && (state_q == ST_INIT) && init_last) begin
            state_d = ST_ACTIVE;
        end
    end

    // FSM outputs: upstream is sampled only when the next symbol may carry data.
    always_comb begin
        take_input = (state_q == ST_ACTIVE) || init_last;
        load       = boundary && take_input;
    end

    // Datapath next state: shift on every edge; at a boundary, pick data or filler and update the flags.
    always_comb begin
        sh_d        = {sh_q[6:0], 1'b0};
        cnt_d       = cnt_q + 3'd1;
        scnt_d      = scnt_q;
        last_data_d = last_data_q;
        sym_valid_d = sym_valid_q;
        underrun_d  = 1'b0;
        sel_valid   = 1'b0;
        if (boundary) begin
            // Forced alignment symbols ignore valid_in entirely.
            sel_valid   = take_input && valid_in;
            sh_d        = sel_valid ? data_in : IDLE_SYMBOL;
            cnt_d       = 3'd0;
            if (!take_input) begin
                scnt_d = scnt_q + 4'd1;
            end
            sym_valid_d = sel_valid;
            last_data_d = sel_valid;
            // Filler that directly follows a data symbol flags a starved upstream.
            underrun_d  = (state_q == ST_ACTIVE) && !sel_valid && last_data_q;
        end
    end

    // Datapath registers: reset to the first bit of an alignment symbol, with no data and no underrun.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sh_q        <= IDLE_SYMBOL;
            cnt_q       <= 3'd0;
            scnt_q      <= 4'd0;
            last_data_q <= 1'b0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            scnt_q      <= scnt_d;
            last_data_q <= last_data_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign data_out     = sh_q[7];
    assign symbol_valid = sym_valid_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed testbench for byte_serializer.
// One instance uses the default parameters. A second instance uses INIT_SYMBOLS=1.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       load, data_out, symbol_valid, underrun;

    logic       reset1_L;
    logic [7:0] data1_in;
    logic       valid1_in;
    logic       load1, data1_out, symbol1_valid, underrun1;

    int tests = 0;
    int fails = 0;

    byte_serializer dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .load         (load),
        .data_out     (data_out),
        .symbol_valid (symbol_valid),
        .underrun     (underrun)
    );

    byte_serializer #(.IDLE_SYMBOL(8'hBC), .INIT_SYMBOLS(1)) dut1 (
        .clk          (clk),
        .reset_L      (reset1_L),
        .data_in      (data1_in),
        .valid_in     (valid1_in),
        .load         (load1),
        .data_out     (data1_out),
        .symbol_valid (symbol1_valid),
        .underrun     (underrun1)
    );

    always #5 clk = ~clk;

    // Advance one bit period; the bench always sits on a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset the default instance and return at the falling edge inside cycle 0.
    task automatic reset_dut();
        @(negedge clk);
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic run_to(input int n);
        reset_dut();
        repeat (n) step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        tests++; if (data_out !== 1'b1) begin fails++; $display("FAIL reset_data_out got=%b exp=1", data_out); end
        tests++; if (symbol_valid !== 1'b0) begin fails++; $display("FAIL reset_symbol_valid got=%b exp=0", symbol_valid); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        tests++; if (load !== 1'b0) begin fails++; $display("FAIL reset_load got=%b exp=0", load); end
    endtask

    task automatic test_init_train();
        logic [7:0] com;
        com = 8'hBC;
        reset_dut();
        for (int c = 0; c < 32; c++) begin
            tests++; if (data_out !== com[7 - (c % 8)]) begin fails++; $display("FAIL init_bit c=%0d got=%b exp=%b", c, data_out, com[7 - (c % 8)]); end
            tests++; if (load !== (c == 31)) begin fails++; $display("FAIL init_load c=%0d got=%b exp=%b", c, load, (c == 31)); end
            tests++; if (symbol_valid !== 1'b0) begin fails++; $display("FAIL init_sv c=%0d got=%b exp=0", c, symbol_valid); end
            if (c < 31) step();
        end
    endtask

    task automatic test_data();
        logic [7:0] a5;
        logic [7:0] com;
        a5  = 8'hA5;
        com = 8'hBC;
        run_to(31);
        data_in  = 8'hA5;
        valid_in = 1'b1;
        step();
        // Present a data byte equal to the idle symbol at the next load.
        data_in = 8'hBC;
        for (int c = 32; c < 40; c++) begin
            tests++; if (data_out !== a5[39 - c]) begin fails++; $display("FAIL data_bit c=%0d got=%b exp=%b", c, data_out, a5[39 - c]); end
            tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL data_sv c=%0d got=%b exp=1", c, symbol_valid); end
            tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL data_underrun c=%0d got=%b exp=0", c, underrun); end
            tests++; if (load !== (c == 39)) begin fails++; $display("FAIL data_load c=%0d got=%b exp=%b", c, load, (c == 39)); end
            step();
        end
        for (int c = 40; c < 48; c++) begin
            tests++; if (data_out !== com[47 - c]) begin fails++; $display("FAIL idle_as_data_bit c=%0d got=%b exp=%b", c, data_out, com[47 - c]); end
            tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL idle_as_data_sv c=%0d got=%b exp=1", c, symbol_valid); end
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_to(31);
        data_in  = 8'h00;
        valid_in = 1'b1;
        step();
        // Changing the input mid-symbol must not disturb the byte being shifted out.
        data_in = 8'hFF;
        for (int c = 32; c < 48; c++) begin
            tests++; if (data_out !== (c >= 40)) begin fails++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, data_out, (c >= 40)); end
            tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL b2b_sv c=%0d got=%b exp=1", c, symbol_valid); end
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_underrun();
        logic [7:0] b3c;
        logic [7:0] com;
        b3c = 8'h3C;
        com = 8'hBC;
        run_to(31);
        data_in  = 8'h3C;
        valid_in = 1'b1;
        step();
        // This byte has no valid_in, so it must not appear on the line.
        data_in  = 8'h55;
        valid_in = 1'b0;
        for (int c = 32; c < 56; c++) begin
            if (c < 40) begin
                tests++; if (data_out !== b3c[39 - c]) begin fails++; $display("FAIL urun_data_bit c=%0d got=%b exp=%b", c, data_out, b3c[39 - c]); end
                tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL urun_data_sv c=%0d got=%b exp=1", c, symbol_valid); end
            end else begin
                tests++; if (data_out !== com[7 - (c % 8)]) begin fails++; $display("FAIL urun_fill_bit c=%0d got=%b exp=%b", c, data_out, com[7 - (c % 8)]); end
                tests++; if (symbol_valid !== 1'b0) begin fails++; $display("FAIL urun_fill_sv c=%0d got=%b exp=0", c, symbol_valid); end
            end
            tests++; if (underrun !== (c == 40)) begin fails++; $display("FAIL urun_pulse c=%0d got=%b exp=%b", c, underrun, (c == 40)); end
            step();
        end
    endtask

    task automatic test_reset_mid_symbol();
        logic [7:0] com;
        com = 8'hBC;
        run_to(31);
        data_in  = 8'hA5;
        valid_in = 1'b1;
        repeat (5) step();
        // Cycle 36, cnt=4: bit 3 of 0xA5 is 0 and the symbol is data.
        tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL mid_pre_bit got=%b exp=0", data_out); end
        tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_sv got=%b exp=1", symbol_valid); end
        reset_L = 1'b0;
        #1;
        tests++; if (data_out !== 1'b1) begin fails++; $display("FAIL mid_rst_bit got=%b exp=1", data_out); end
        tests++; if (symbol_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_sv got=%b exp=0", symbol_valid); end
        tests++; if (load !== 1'b0) begin fails++; $display("FAIL mid_rst_load got=%b exp=0", load); end
        repeat (2) @(negedge clk);
        // valid_in stays high through the whole INIT train.
        reset_L = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tests++; if (data_out !== com[7 - (c % 8)]) begin fails++; $display("FAIL mid_init_bit c=%0d got=%b exp=%b", c, data_out, com[7 - (c % 8)]); end
            tests++; if (load !== (c == 31)) begin fails++; $display("FAIL mid_init_load c=%0d got=%b exp=%b", c, load, (c == 31)); end
            tests++; if (symbol_valid !== 1'b0) begin fails++; $display("FAIL mid_init_sv c=%0d got=%b exp=0", c, symbol_valid); end
            step();
        end
        tests++; if (data_out !== 1'b1) begin fails++; $display("FAIL mid_after_bit got=%b exp=1", data_out); end
        tests++; if (symbol_valid !== 1'b1) begin fails++; $display("FAIL mid_after_sv got=%b exp=1", symbol_valid); end
        valid_in = 1'b0;
    endtask

    task automatic test_init_one();
        logic [7:0] com;
        logic [7:0] b81;
        com = 8'hBC;
        b81 = 8'h81;
        @(negedge clk);
        reset1_L  = 1'b0;
        data1_in  = 8'h81;
        valid1_in = 1'b1;
        repeat (2) @(negedge clk);
        reset1_L = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
                tests++; if (data1_out !== com[7 - c]) begin fails++; $display("FAIL one_init_bit c=%0d got=%b exp=%b", c, data1_out, com[7 - c]); end
                tests++; if (symbol1_valid !== 1'b0) begin fails++; $display("FAIL one_init_sv c=%0d got=%b exp=0", c, symbol1_valid); end
            end else begin
                tests++; if (data1_out !== b81[15 - c]) begin fails++; $display("FAIL one_data_bit c=%0d got=%b exp=%b", c, data1_out, b81[15 - c]); end
                tests++; if (symbol1_valid !== 1'b1) begin fails++; $display("FAIL one_data_sv c=%0d got=%b exp=1", c, symbol1_valid); end
            end
            tests++; if (load1 !== ((c % 8) == 7)) begin fails++; $display("FAIL one_load c=%0d got=%b exp=%b", c, load1, ((c % 8) == 7)); end
            step();
        end
    endtask

    initial begin
        reset_L   = 1'b0;
        data_in   = 8'h00;
        valid_in  = 1'b0;
        reset1_L  = 1'b0;
        data1_in  = 8'h00;
        valid1_in = 1'b0;
        test_reset();
        test_init_train();
        test_data();
        test_back_to_back();
        test_underrun();
        test_reset_mid_symbol();
        test_init_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial converter for one PCIe lane, placed directly downstream of the 2:1 byte lane mux. It consumes one 8-bit symbol per eight clocks and shifts it out MSB first on a 1-bit line. After reset it emits a fixed train of COM (0xBC) alignment symbols. Once aligned, it inserts COM filler whenever the upstream byte is not valid.

## Interface
- `IDLE_SYMBOL`, default 8'hBC: filler and alignment symbol.
- `INIT_SYMBOLS`, default 4: number of `IDLE_SYMBOL` symbols forced after reset. Legal range is 1..15.

- `clk`: input, 1 bit. Bit clock; one serial bit per cycle.
- `reset_L`: input, 1 bit. Asynchronous, active-low reset.
- `data_in`: input, 8 bits. Byte from the upstream mux.
- `valid_in`: input, 1 bit. `data_in` is a real data symbol.
- `load`: output, 1 bit. Byte-request strobe. The block captures `data_in`/`valid_in` at the rising edge that ends a cycle with `load`=1.
- `data_out`: output, 1 bit. Serial line.
- `symbol_valid`: output, 1 bit. The bit currently on `data_out` belongs to a data symbol, not filler.
- `underrun`: output, 1 bit. One-cycle pulse when filler follows a data symbol in ACTIVE.

## Operation
- State:
  - shift register `sh[7:0]`
  - bit counter `cnt[2:0]`
  - symbol counter `scnt[3:0]`
  - FSM state in {INIT, ACTIVE}
  - flag `last_data`
- `data_out` = `sh[7]`. All outputs are registered or decoded only from registers; no combinational path from `data_in`/`valid_in` to any output.
- Reset (async, `reset_L`=0) drives, immediately:
  - `sh`=`IDLE_SYMBOL`, `cnt`=0, `scnt`=0, state=INIT, `last_data`=0
  - `data_out`=1 (MSB of 0xBC), `symbol_valid`=0, `underrun`=0, `load`=0
- Every rising edge with `cnt`≠7: `sh` shifts left by one, `cnt`+1.
- Rising edge with `cnt`=7 is the symbol boundary. `cnt`←0 and `sh` takes the next symbol:
  - INIT, `scnt` < `INIT_SYMBOLS`-1: `IDLE_SYMBOL`; `scnt`+1.
  - INIT, `scnt` = `INIT_SYMBOLS`-1: `valid_in` ? `data_in` : `IDLE_SYMBOL`; state←ACTIVE.
  - ACTIVE: `valid_in` ? `data_in` : `IDLE_SYMBOL`.
- `load` = (`cnt`==7) & (state==ACTIVE | `scnt`==`INIT_SYMBOLS`-1). It is never high in other INIT symbols.
- At each boundary:
  - `symbol_valid` ← selected `valid_in` (0 for forced INIT symbols); it holds for the 8 cycles of that symbol.
  - `last_data` ← same value.
- `underrun` ← 1 for exactly one cycle when a boundary in ACTIVE selects filler and `last_data`=1. It is 0 otherwise.
- In ACTIVE, `data_in` is ignored when `valid_in`=0. A data byte equal to `IDLE_SYMBOL` with `valid_in`=1 is sent as data (`symbol_valid`=1).
- No state returns to INIT except reset.

## Timing
- Cycle 0 is the first cycle after `reset_L` rises; `cnt`=0 in cycle 0.
- INIT occupies cycles 0..8·`INIT_SYMBOLS`-1. The first `load` occurs in cycle 8·`INIT_SYMBOLS`-1.
- Latency: a byte captured at edge E shows its MSB on `data_out` in the cycle right after E, and its LSB 7 cycles later.
- Throughput: exactly one symbol per 8 cycles. `load` has period 8 in ACTIVE, with no gap between consecutive symbols.
- Upstream must hold `data_in`/`valid_in` stable through the `load` cycle; values outside `load` cycles have no effect.
- Reset mid-symbol: outputs take reset values within the same cycle, and the partial symbol is discarded. After release, the full INIT train repeats.

## Test plan
1. Reset release, `valid_in`=0, default parameters → `data_out` = 1,0,1,1,1,1,0,0 repeated in cycles 0..31; `load`=0 until cycle 31; `symbol_valid`=0 throughout.
2. `data_in`=8'hA5, `valid_in`=1 at cycle 31 → cycles 32..39 give `data_out` 1,0,1,0,0,1,0,1; `symbol_valid`=1 on 32..39; `underrun`=0.
3. Back-to-back 8'h00 then 8'hFF at loads in cycles 31 and 39 → eight 0s (cycles 32..39), then eight 1s (40..47); `symbol_valid` stays 1 with no gap.
4. 8'h3C at cycle 31, `valid_in`=0 at cycle 39 → cycles 32..39 send 0,0,1,1,1,1,0,0; cycles 40..47 send 0xBC; `symbol_valid`=0 at 40; `underrun`=1 in cycle 40 only.
5. Assert `reset_L`=0 at `cnt`=4 of a data symbol → same cycle: `data_out`=1, `symbol_valid`=0, `load`=0. After release, 32 cycles of COM, then `load` in cycle 31.
6. `INIT_SYMBOLS`=1 → a single COM in cycles 0..7, `load` in cycle 7; the data byte 8'h81 presented then appears as 1,0,0,0,0,0,0,1 in cycles 8..15.
